// File: rtl/lsb_mem_responder.sv
// Memory-side responder for the load/store buffer.
// Serializes one load or store at a time into byte accesses on the 8-bit
// RAM/IO bus, assembles and extends load data, and pulses completion.
module lsb_mem_responder #(
  parameter logic [6:0] LD_TYPE    = 7'b0000011,
  parameter logic [6:0] ST_TYPE    = 7'b0100011,
  parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rob_clear,
  input  logic        in_lsb_ready,
  input  logic [2:0]  op_in,
  input  logic [6:0]  instr_type_in,
  input  logic [31:0] data_addr_in,
  input  logic [31:0] data_in,
  output logic        welcome_lsb,
  output logic        cache_ready,
  output logic [6:0]  cache_instr_type,
  output logic [31:0] cache_data_out,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  localparam int unsigned CNT_W  = 3;
  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [6:0]        type_q, type_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] asm_q, asm_d;
  logic [7:0]        din_q;
  logic              stall_q;

  logic              welcome_d;
  logic              ready_d;
  logic [6:0]        ctype_d;
  logic [DATA_W-1:0] cdata_d;
  logic [DATA_W-1:0] mem_a_d;
  logic [7:0]        mem_dout_d;
  logic              mem_wr_d;

  logic [CNT_W-1:0]  n_bytes;
  logic [1:0]        cap_idx;
  logic [7:0]        din_sel;
  logic [DATA_W-1:0] asm_cap;
  logic [DATA_W-1:0] ext;
  logic [DATA_W-1:0] done_data;
  logic              io_stall;

  // Reads are pipelined two deep behind mem_a; a rdy-low freeze would drop
  // the byte arriving on the first frozen edge, so it is parked in din_q
  // and used on the resume edge instead of mem_din.
  always_comb begin
    n_bytes = CNT_W'(4);
    case (op_q[1:0])
      2'b00:   n_bytes = CNT_W'(1);
      2'b01:   n_bytes = CNT_W'(2);
      default: n_bytes = CNT_W'(4);
    endcase
    cap_idx = 2'(cnt - CNT_W'(2));
    din_sel = stall_q ? din_q : mem_din;
    asm_cap = asm_q;
    asm_cap[{cap_idx, 3'b000} +: 8] = din_sel;
    case (op_q)
      3'b000:  ext = {{24{asm_cap[7]}}, asm_cap[7:0]};
      3'b001:  ext = {{16{asm_cap[15]}}, asm_cap[15:0]};
      3'b100:  ext = {24'd0, asm_cap[7:0]};
      3'b101:  ext = {16'd0, asm_cap[15:0]};
      default: ext = asm_cap;
    endcase
    done_data = (type_q == ST_TYPE) ? '0 : ext;
    io_stall  = (addr_q[17:16] == IO_ADDR_HI) && io_buffer_full;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    op_d       = op_q;
    type_d     = type_q;
    addr_d     = addr_q;
    data_d     = data_q;
    asm_d      = asm_q;
    welcome_d  = welcome_lsb;
    ready_d    = 1'b0;
    ctype_d    = cache_instr_type;
    cdata_d    = cache_data_out;
    mem_a_d    = mem_a;
    mem_dout_d = mem_dout;
    mem_wr_d   = 1'b0;

    case (state)
      S_IDLE: begin
        welcome_d = 1'b1;
        if (in_lsb_ready && !rob_clear) begin
          op_d      = op_in;
          type_d    = instr_type_in;
          addr_d    = data_addr_in;
          data_d    = data_in;
          asm_d     = '0;
          cnt_d     = '0;
          welcome_d = 1'b0;
          state_d   = (instr_type_in == LD_TYPE) ? S_READ : S_WRITE;
        end
      end

      S_READ: begin
        if (rob_clear) begin
          state_d   = S_IDLE;
          welcome_d = 1'b1;
          cnt_d     = '0;
        end else begin
          if (cnt < n_bytes) begin
            mem_a_d = addr_q + DATA_W'(cnt);
          end
          if (cnt >= CNT_W'(2)) begin
            asm_d = asm_cap;
          end
          if (cnt == n_bytes + CNT_W'(1)) begin
            state_d = S_DONE;
            ready_d = 1'b1;
            ctype_d = type_q;
            cdata_d = done_data;
          end
          cnt_d = cnt + CNT_W'(1);
        end
      end

      S_WRITE: begin
        if (cnt == n_bytes) begin
          state_d = S_DONE;
          ready_d = 1'b1;
          ctype_d = type_q;
          cdata_d = done_data;
        end else if (!io_stall) begin
          mem_a_d    = addr_q + DATA_W'(cnt);
          mem_dout_d = data_q[{cnt[1:0], 3'b000} +: 8];
          mem_wr_d   = 1'b1;
          cnt_d      = cnt + CNT_W'(1);
        end
      end

      default: begin
        state_d   = S_IDLE;
        welcome_d = 1'b1;
        cnt_d     = '0;
      end
    endcase
  end

  // State and output registers; rdy low holds everything but drops mem_wr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= S_IDLE;
      cnt              <= '0;
      op_q             <= '0;
      type_q           <= '0;
      addr_q           <= '0;
      data_q           <= '0;
      asm_q            <= '0;
      din_q            <= '0;
      stall_q          <= 1'b0;
      welcome_lsb      <= 1'b1;
      cache_ready      <= 1'b0;
      cache_instr_type <= '0;
      cache_data_out   <= '0;
      mem_a            <= '0;
      mem_dout         <= '0;
      mem_wr           <= 1'b0;
    end else if (!rdy) begin
      mem_wr  <= 1'b0;
      stall_q <= 1'b1;
      if (!stall_q) begin
        din_q <= mem_din;
      end
    end else begin
      stall_q          <= 1'b0;
      state            <= state_d;
      cnt              <= cnt_d;
      op_q             <= op_d;
      type_q           <= type_d;
      addr_q           <= addr_d;
      data_q           <= data_d;
      asm_q            <= asm_d;
      welcome_lsb      <= welcome_d;
      cache_ready      <= ready_d;
      cache_instr_type <= ctype_d;
      cache_data_out   <= cdata_d;
      mem_a            <= mem_a_d;
      mem_dout         <= mem_dout_d;
      mem_wr           <= mem_wr_d;
    end
  end

endmodule

// File: tb/tb_lsb_mem_responder.sv
// Scoreboard bench for lsb_mem_responder: stimulus pushes expected
// completions and bus writes; a negedge monitor pops and compares them.
module tb_lsb_mem_responder;

  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        rob_clear = 1'b0;
  logic        in_lsb_ready = 1'b0;
  logic [2:0]  op_in = '0;
  logic [6:0]  instr_type_in = '0;
  logic [31:0] data_addr_in = '0;
  logic [31:0] data_in = '0;
  logic        welcome_lsb;
  logic        cache_ready;
  logic [6:0]  cache_instr_type;
  logic [31:0] cache_data_out;
  logic [7:0]  mem_din = '0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;

  lsb_mem_responder dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rob_clear(rob_clear),
    .in_lsb_ready(in_lsb_ready), .op_in(op_in), .instr_type_in(instr_type_in),
    .data_addr_in(data_addr_in), .data_in(data_in), .welcome_lsb(welcome_lsb),
    .cache_ready(cache_ready), .cache_instr_type(cache_instr_type),
    .cache_data_out(cache_data_out), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [6:0] typ; logic [31:0] data; int cyc; } resp_t;
  typedef struct { logic [31:0] a; logic [7:0] d; int cyc; } wr_t;
  resp_t resp_q[$];
  wr_t   wr_q[$];

  int check_cnt = 0;
  int fail_cnt  = 0;

  logic [7:0] ram [0:1023];

  // Synchronous RAM: read data appears the cycle after the address.
  always @(posedge clk) begin
    if (mem_wr) ram[mem_a[9:0]] <= mem_dout;
    mem_din <= ram[mem_a[9:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every completion pulse and bus write must match the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      if (cache_ready) begin
        if (resp_q.size() == 0) begin
          check_cnt++; fail_cnt++;
          $display("FAIL unexpected_ready actual=1 required=0 cycle=%0d", cyc);
        end else begin
          resp_t e;
          e = resp_q.pop_front();
          chk("resp_type", 32'(cache_instr_type), 32'(e.typ));
          chk("resp_data", cache_data_out, e.data);
          chk("resp_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (mem_wr) begin
        if (wr_q.size() == 0) begin
          check_cnt++; fail_cnt++;
          $display("FAIL unexpected_write actual=1 required=0 addr=0x%08h cycle=%0d", mem_a, cyc);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          chk("wr_addr", mem_a, w.a);
          chk("wr_data", 32'(mem_dout), 32'(w.d));
          chk("wr_cycle", 32'(cyc), 32'(w.cyc));
        end
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [6:0] typ,
                       input logic [31:0] addr, input logic [31:0] d, output int t);
    int g;
    g = 0;
    while (!welcome_lsb && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!welcome_lsb) begin
      check_cnt++; fail_cnt++;
      $display("FAIL issue_wait actual=0 required=1");
    end
    op_in = op; instr_type_in = typ; data_addr_in = addr; data_in = d;
    in_lsb_ready = 1'b1;
    t = cyc + 1;
    @(negedge clk);
    in_lsb_ready = 1'b0;
  endtask

  task automatic push_resp(input logic [6:0] typ, input logic [31:0] d, input int c);
    resp_t e;
    e.typ = typ; e.data = d; e.cyc = c;
    resp_q.push_back(e);
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [7:0] d, input int c);
    wr_t w;
    w.a = a; w.d = d; w.cyc = c;
    wr_q.push_back(w);
  endtask

  task automatic wait_done(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (resp_q.size() == 0 && wr_q.size() == 0 && welcome_lsb) done = 1'b1;
    end
    if (!done) begin
      check_cnt++; fail_cnt++;
      $display("FAIL %s_timeout actual=pending%0d required=0", name, resp_q.size() + wr_q.size());
      resp_q.delete();
      wr_q.delete();
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [31:0] sw_val;
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    ram[10'h100] = 8'h78; ram[10'h101] = 8'h56; ram[10'h102] = 8'h34; ram[10'h103] = 8'h12;
    ram[10'h200] = 8'h80; ram[10'h201] = 8'hFE; ram[10'h202] = 8'hFF;

    repeat (3) @(negedge clk);
    chk("rst_welcome", 32'(welcome_lsb), 32'd1);
    chk("rst_ready", 32'(cache_ready), 32'd0);
    chk("rst_type", 32'(cache_instr_type), 32'd0);
    chk("rst_data", cache_data_out, 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_dout", 32'(mem_dout), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // LW with address walk check
    issue(3'b010, LD, 32'h100, 32'h0, t);
    push_resp(LD, 32'h12345678, t + 6);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("lw_mem_a", mem_a, 32'h100 + 32'(k));
    end
    wait_done("lw");

    issue(3'b000, LD, 32'h200, 32'h0, t); push_resp(LD, 32'hFFFFFF80, t + 3); wait_done("lb");
    issue(3'b100, LD, 32'h200, 32'h0, t); push_resp(LD, 32'h00000080, t + 3); wait_done("lbu");
    issue(3'b001, LD, 32'h201, 32'h0, t); push_resp(LD, 32'hFFFFFFFE, t + 4); wait_done("lh");
    issue(3'b101, LD, 32'h201, 32'h0, t); push_resp(LD, 32'h0000FFFE, t + 4); wait_done("lhu");

    // SW then read back
    sw_val = 32'hAABBCCDD;
    issue(3'b010, ST, 32'h300, sw_val, t);
    for (int k = 0; k < 4; k++) push_wr(32'h300 + 32'(k), sw_val[8*k +: 8], t + 1 + k);
    push_resp(ST, 32'h0, t + 5);
    wait_done("sw");
    issue(3'b010, LD, 32'h300, 32'h0, t); push_resp(LD, 32'hAABBCCDD, t + 6); wait_done("lw_back");

    // SB to IO with buffer full for three cycles
    io_buffer_full = 1'b1;
    issue(3'b000, ST, 32'h00030000, 32'h00000041, t);
    push_wr(32'h00030000, 8'h41, t + 4);
    push_resp(ST, 32'h0, t + 5);
    repeat (3) @(negedge clk);
    io_buffer_full = 1'b0;
    wait_done("sb_io");

    // LW flushed mid-read: no completion
    issue(3'b010, LD, 32'h100, 32'h0, t);
    @(negedge clk);
    @(negedge clk);
    rob_clear = 1'b1;
    @(negedge clk);
    chk("lw_flush_welcome", 32'(welcome_lsb), 32'd1);
    chk("lw_flush_mem_wr", 32'(mem_wr), 32'd0);
    rob_clear = 1'b0;
    repeat (8) @(negedge clk);

    // SW flushed mid-write still completes
    sw_val = 32'h11223344;
    issue(3'b010, ST, 32'h310, sw_val, t);
    for (int k = 0; k < 4; k++) push_wr(32'h310 + 32'(k), sw_val[8*k +: 8], t + 1 + k);
    push_resp(ST, 32'h0, t + 5);
    @(negedge clk);
    @(negedge clk);
    rob_clear = 1'b1;
    @(negedge clk);
    rob_clear = 1'b0;
    wait_done("sw_flush");

    // rdy low for two cycles mid-LW
    issue(3'b010, LD, 32'h100, 32'h0, t);
    push_resp(LD, 32'h12345678, t + 8);
    @(negedge clk);
    @(negedge clk);
    chk("rdy_mem_a_pre", mem_a, 32'h101);
    rdy = 1'b0;
    @(negedge clk);
    chk("rdy_mem_a_hold1", mem_a, 32'h101);
    @(negedge clk);
    chk("rdy_mem_a_hold2", mem_a, 32'h101);
    rdy = 1'b1;
    @(negedge clk);
    chk("rdy_mem_a_resume", mem_a, 32'h102);
    wait_done("lw_rdy");

    // Async reset mid-write: only the first byte lands in RAM
    issue(3'b010, ST, 32'h320, 32'h55667788, t);
    push_wr(32'h320, 8'h88, t + 1);
    push_wr(32'h321, 8'h77, t + 2);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_mem_wr", 32'(mem_wr), 32'd0);
    chk("arst_welcome", 32'(welcome_lsb), 32'd1);
    chk("arst_ready", 32'(cache_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    issue(3'b001, LD, 32'h320, 32'h0, t); push_resp(LD, 32'h00000088, t + 4); wait_done("lh_after_rst");

    repeat (3) @(negedge clk);
    chk("resp_q_empty", 32'(resp_q.size()), 32'd0);
    chk("wr_q_empty", 32'(wr_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
    $finish;
  end

endmodule
